// File: rtl/iq_unpack.sv
// Byte-stream to I/Q sample unpacker: gathers I_lo, I_hi, Q_lo, Q_hi from a FWFT FIFO,
// sign-extends and scales each 16-bit sample, then writes the I and Q FIFOs together.
module iq_unpack #(
    parameter int QUANT_BITS       = 10,
    parameter int BYTES_PER_SAMPLE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_dout,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [31:0] i_out,
    output logic [31:0] q_out,
    output logic        i_wr_en,
    output logic        q_wr_en,
    input  logic        i_full,
    input  logic        q_full
);

    // FIFO handshake: a byte transfers on any rising edge where in_rd_en=1 (only
    // ever raised while in_empty=0); a sample pair transfers on any edge where
    // i_wr_en=q_wr_en=1 (only ever raised while both i_full and q_full are 0).

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_SAMPLE - 1);

    typedef enum logic [1:0] {
        S_READ  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt, byte_cnt_next;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  b0_next, b1_next, b2_next;
    logic [31:0] i_reg, q_reg, i_next, q_next;

    function automatic logic [31:0] quantize(input logic [15:0] s);
        return {{16{s[15]}}, s} << QUANT_BITS;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_READ;
            byte_cnt <= 2'd0;
            b0       <= 8'd0;
            b1       <= 8'd0;
            b2       <= 8'd0;
            i_reg    <= 32'd0;
            q_reg    <= 32'd0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            b0       <= b0_next;
            b1       <= b1_next;
            b2       <= b2_next;
            i_reg    <= i_next;
            q_reg    <= q_next;
        end
    end

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        b0_next       = b0;
        b1_next       = b1;
        b2_next       = b2;
        i_next        = i_reg;
        q_next        = q_reg;
        in_rd_en      = 1'b0;
        i_wr_en       = 1'b0;
        q_wr_en       = 1'b0;
        i_out         = 32'd0;
        q_out         = 32'd0;

        case (state)
            S_READ: begin
                in_rd_en = !in_empty;
                if (in_rd_en) begin
                    byte_cnt_next = byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    b0_next = in_dout;
                        2'd1:    b1_next = in_dout;
                        2'd2:    b2_next = in_dout;
                        default: ;
                    endcase
                    // The final byte is used straight from the FIFO head.
                    if (byte_cnt == LAST_BYTE) begin
                        i_next     = quantize({b1, b0});
                        q_next     = quantize({in_dout, b2});
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!i_full && !q_full) begin
                    i_wr_en       = 1'b1;
                    q_wr_en       = 1'b1;
                    i_out         = i_reg;
                    q_out         = q_reg;
                    byte_cnt_next = 2'd0;
                    state_next    = S_READ;
                end
            end
            default: begin
                state_next    = S_READ;
                byte_cnt_next = 2'd0;
            end
        endcase

        // The state register still holds its old value during the reset cycle.
        if (reset) begin
            in_rd_en = 1'b0;
            i_wr_en  = 1'b0;
            q_wr_en  = 1'b0;
            i_out    = 32'd0;
            q_out    = 32'd0;
        end
    end

endmodule

// File: tb/tb_iq_unpack.sv
// Directed bench for iq_unpack: table-driven sample vectors plus stall, gap,
// reset-abort and throughput sequences against a FIFO-side byte source.
module tb_iq_unpack;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] i_out, q_out;
    logic        i_wr_en, q_wr_en;
    logic        i_full, q_full;

    iq_unpack dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .i_out    (i_out),
        .q_out    (q_out),
        .i_wr_en  (i_wr_en),
        .q_wr_en  (q_wr_en),
        .i_full   (i_full),
        .q_full   (q_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] ei, eq;
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  src_q[$];
    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          last_wr_cyc = -1;
    int          gap_cnt = 0;
    int          gap_min = 0;
    int          gap_max = 0;
    bit          rand_full = 0;
    bit          check_rate = 0;
    bit          expect_no_rd = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_pair(input logic [7:0] b0, b1, b2, b3);
        int si, sq;
        si = int'($signed({b1, b0}));
        sq = int'($signed({b3, b2}));
        return {32'(si * 1024), 32'(sq * 1024)};
    endfunction

    task automatic drive_inputs();
        in_empty = (gap_cnt > 0) || (src_q.size() == 0);
        in_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    task automatic push_pair(input logic [7:0] b0, b1, b2, b3);
        src_q.push_back(b0);
        src_q.push_back(b1);
        src_q.push_back(b2);
        src_q.push_back(b3);
        drive_inputs();
    endtask

    // One clock: sample and check at the falling edge, update the sources after the rising edge.
    task automatic cycle();
        logic popped;
        @(negedge clock);
        check("rd_while_empty", 64'(in_rd_en & in_empty), 64'd0);
        check("strobes_lockstep", 64'(i_wr_en), 64'(q_wr_en));
        if (expect_no_rd) check("rd_during_stall", 64'(in_rd_en), 64'd0);
        if (reset) begin
            check("reset_strobes", 64'({in_rd_en, i_wr_en, q_wr_en}), 64'd0);
            check("reset_data", {i_out, q_out}, 64'd0);
        end
        if (i_wr_en || q_wr_en) begin
            check("write_while_full", 64'(i_full | q_full), 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got i=%h q=%h, required no write (cycle %0d)",
                         i_out, q_out, cyc);
            end else begin
                check("sample", {i_out, q_out}, exp_q.pop_front());
            end
            if (check_rate && last_wr_cyc >= 0) check("write_period", 64'(cyc - last_wr_cyc), 64'd5);
            last_wr_cyc = cyc;
            wr_count++;
        end else begin
            check("idle_data", {i_out, q_out}, 64'd0);
        end
        popped = in_rd_en & ~in_empty;
        @(posedge clock);
        #1;
        cyc++;
        if (popped && src_q.size() > 0) begin
            void'(src_q.pop_front());
            gap_cnt = (gap_max > 0) ? int'($urandom_range(gap_max, gap_min)) : 0;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        if (rand_full) begin
            i_full = ($urandom_range(0, 3) == 0);
            q_full = ($urandom_range(0, 3) == 0);
        end
        drive_inputs();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (exp_q.size() > 0 || src_q.size() > 0); i++) cycle();
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) cycle();
    endtask

    initial begin
        int start_cyc;
        int w0;
        logic [7:0] rb0, rb1, rb2, rb3;

        vecs[0] = '{8'h01, 8'h00, 8'h02, 8'h00, 32'h0000_0400, 32'h0000_0800};
        vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 32'hFFFF_FC00, 32'hFE00_0000};
        vecs[2] = '{8'hFF, 8'h7F, 8'h00, 8'h00, 32'h01FF_FC00, 32'h0000_0000};
        vecs[3] = '{8'h34, 8'h12, 8'hCC, 8'hED, 32'h0048_D000, 32'hFFB7_3000};

        reset  = 1'b1;
        i_full = 1'b0;
        q_full = 1'b0;
        drive_inputs();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Directed vectors, no gaps: write exactly one cycle after the 4th pop.
        for (int v = 0; v < 4; v++) begin
            start_cyc = cyc;
            w0 = wr_count;
            exp_q.push_back({vecs[v].ei, vecs[v].eq});
            push_pair(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
            drain(50);
            check("latency", 64'(last_wr_cyc - start_cyc), 64'd4);
            check("write_count", 64'(wr_count - w0), 64'd1);
        end

        // Q FIFO full after the pair is assembled; the next pair waits behind it.
        q_full = 1'b1;
        w0 = wr_count;
        exp_q.push_back({32'h0000_0400, 32'h0000_0800});
        exp_q.push_back({32'h0000_1400, 32'hFFFF_EC00});
        push_pair(8'h01, 8'h00, 8'h02, 8'h00);
        push_pair(8'h05, 8'h00, 8'hFB, 8'hFF);
        repeat (4) cycle();
        expect_no_rd = 1'b1;
        repeat (10) cycle();
        expect_no_rd = 1'b0;
        check("stall_no_write", 64'(wr_count - w0), 64'd0);
        q_full = 1'b0;
        cycle();
        check("release_write", 64'(wr_count - w0), 64'd1);
        drain(50);
        check("stall_total", 64'(wr_count - w0), 64'd2);

        // Empty gaps of 1-3 cycles between every byte.
        gap_min = 1;
        gap_max = 3;
        w0 = wr_count;
        exp_q.push_back({32'h0000_0400, 32'h0000_0800});
        push_pair(8'h01, 8'h00, 8'h02, 8'h00);
        drain(100);
        check("gap_write_count", 64'(wr_count - w0), 64'd1);
        gap_min = 0;
        gap_max = 0;

        // Reset after two bytes discards them; bytes still queued are not consumed during reset.
        w0 = wr_count;
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        push_pair(8'h03, 8'h00, 8'h04, 8'h00);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_kept_bytes", 64'(src_q.size()), 64'd4);
        exp_q.push_back({32'h0000_0C00, 32'h0000_1000});
        drain(50);
        check("reset_write_count", 64'(wr_count - w0), 64'd1);

        // 100 back-to-back random pairs: one write every 5 cycles.
        w0 = wr_count;
        for (int p = 0; p < 100; p++) begin
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            rb2 = 8'($urandom_range(0, 255));
            rb3 = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_pair(rb0, rb1, rb2, rb3));
            push_pair(rb0, rb1, rb2, rb3);
        end
        check_rate = 1'b1;
        last_wr_cyc = -1;
        drain(1000);
        check_rate = 1'b0;
        check("burst_write_count", 64'(wr_count - w0), 64'd100);

        // Same traffic shape with random empty gaps and random full on either side.
        w0 = wr_count;
        gap_min = 0;
        gap_max = 2;
        rand_full = 1'b1;
        for (int p = 0; p < 100; p++) begin
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            rb2 = 8'($urandom_range(0, 255));
            rb3 = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_pair(rb0, rb1, rb2, rb3));
            push_pair(rb0, rb1, rb2, rb3);
        end
        drain(5000);
        rand_full = 1'b0;
        i_full = 1'b0;
        q_full = 1'b0;
        gap_max = 0;
        repeat (3) cycle();
        check("stall_write_count", 64'(wr_count - w0), 64'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
